// File: rtl/sbox_forward_pipe.sv
// sbox_forward_pipe: three-stage valid/ready pipelined AES forward S-box built on the depth-16 tower-field circuit
module sbox_forward_pipe (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);
  typedef struct packed {
    logic t1, t2, t3, t4, t6, t8, t9, t10, t13, t14, t15;
    logic t16, t17, t19, t20, t22, t23, t24, t25, t26, t27, d;
  } top_t;
  typedef struct packed {
    logic m46, m47, m48, m49, m50, m51, m52, m53, m54;
    logic m55, m56, m57, m58, m59, m60, m61, m62, m63;
  } core_t;
  logic [27:1] t;
  logic [45:1] m;
  logic [29:0] l;
  top_t        s1_d, s1_q;
  core_t       s2_d, s2_q;
  logic [7:0]  s3_d, s3_q;
  logic        v1_q, v2_q, v3_q;
  logic        adv1, adv2, adv3;
  assign adv3      = !v3_q || out_ready;
  assign adv2      = !v2_q || adv3;
  assign adv1      = !v1_q || adv2;
  assign in_ready  = reset_n && !flush && adv1;
  assign out_valid = v3_q;
  assign out_data  = v3_q ? s3_q : 8'h00;
  assign busy      = v1_q || v2_q || v3_q;
  // Top linear layer: in_data[7] is circuit input U0, in_data[0] is U7
  always_comb begin
    t[1]  = in_data[7] ^ in_data[4]; t[2]  = in_data[7] ^ in_data[2]; t[3]  = in_data[7] ^ in_data[1];
    t[4]  = in_data[4] ^ in_data[2]; t[5]  = in_data[3] ^ in_data[1]; t[6]  = t[1] ^ t[5];
    t[7]  = in_data[6] ^ in_data[5]; t[8]  = in_data[0] ^ t[6];       t[9]  = in_data[0] ^ t[7];
    t[10] = t[6] ^ t[7];             t[11] = in_data[6] ^ in_data[2]; t[12] = in_data[5] ^ in_data[2];
    t[13] = t[3] ^ t[4];             t[14] = t[6] ^ t[11];            t[15] = t[5] ^ t[11];
    t[16] = t[5] ^ t[12];            t[17] = t[9] ^ t[16];            t[18] = in_data[4] ^ in_data[0];
    t[19] = t[7] ^ t[18];            t[20] = t[1] ^ t[19];            t[21] = in_data[1] ^ in_data[0];
    t[22] = t[7] ^ t[21];            t[23] = t[2] ^ t[22];            t[24] = t[2] ^ t[10];
    t[25] = t[20] ^ t[17];           t[26] = t[3] ^ t[16];            t[27] = t[1] ^ t[12];
    s1_d = '{t1: t[1], t2: t[2], t3: t[3], t4: t[4], t6: t[6], t8: t[8], t9: t[9], t10: t[10],
             t13: t[13], t14: t[14], t15: t[15], t16: t[16], t17: t[17], t19: t[19], t20: t[20],
             t22: t[22], t23: t[23], t24: t[24], t25: t[25], t26: t[26], t27: t[27], d: in_data[0]};
  end
  // Nonlinear core: GF(2^4) tower inversion followed by the output multiplications
  always_comb begin
    m[1]  = s1_q.t13 & s1_q.t6;  m[2]  = s1_q.t23 & s1_q.t8;  m[3]  = s1_q.t14 ^ m[1];
    m[4]  = s1_q.t19 & s1_q.d;   m[5]  = m[4] ^ m[1];         m[6]  = s1_q.t3 & s1_q.t16;
    m[7]  = s1_q.t22 & s1_q.t9;  m[8]  = s1_q.t26 ^ m[6];     m[9]  = s1_q.t20 & s1_q.t17;
    m[10] = m[9] ^ m[6];         m[11] = s1_q.t1 & s1_q.t15;  m[12] = s1_q.t4 & s1_q.t27;
    m[13] = m[12] ^ m[11];       m[14] = s1_q.t2 & s1_q.t10;  m[15] = m[14] ^ m[11];
    m[16] = m[3] ^ m[2];         m[17] = m[5] ^ s1_q.t24;     m[18] = m[8] ^ m[7];
    m[19] = m[10] ^ m[15];       m[20] = m[16] ^ m[13];       m[21] = m[17] ^ m[15];
    m[22] = m[18] ^ m[13];       m[23] = m[19] ^ s1_q.t25;    m[24] = m[22] ^ m[23];
    m[25] = m[22] & m[20];       m[26] = m[21] ^ m[25];       m[27] = m[20] ^ m[21];
    m[28] = m[23] ^ m[25];       m[29] = m[28] & m[27];       m[30] = m[26] & m[24];
    m[31] = m[20] & m[23];       m[32] = m[27] & m[31];       m[33] = m[27] ^ m[25];
    m[34] = m[21] & m[22];       m[35] = m[24] & m[34];       m[36] = m[24] ^ m[25];
    m[37] = m[21] ^ m[29];       m[38] = m[32] ^ m[33];       m[39] = m[23] ^ m[30];
    m[40] = m[35] ^ m[36];       m[41] = m[38] ^ m[40];       m[42] = m[37] ^ m[39];
    m[43] = m[37] ^ m[38];       m[44] = m[39] ^ m[40];       m[45] = m[42] ^ m[41];
    s2_d = '{m46: m[44] & s1_q.t6,  m47: m[40] & s1_q.t8,  m48: m[39] & s1_q.d,
             m49: m[43] & s1_q.t16, m50: m[38] & s1_q.t9,  m51: m[37] & s1_q.t17,
             m52: m[42] & s1_q.t15, m53: m[45] & s1_q.t27, m54: m[41] & s1_q.t10,
             m55: m[44] & s1_q.t13, m56: m[40] & s1_q.t23, m57: m[39] & s1_q.t19,
             m58: m[43] & s1_q.t3,  m59: m[38] & s1_q.t22, m60: m[37] & s1_q.t20,
             m61: m[42] & s1_q.t1,  m62: m[45] & s1_q.t4,  m63: m[41] & s1_q.t2};
  end
  // Bottom linear layer; the inverted outputs fold in the 0x63 affine constant
  always_comb begin
    l[0]  = s2_q.m61 ^ s2_q.m62; l[1]  = s2_q.m50 ^ s2_q.m56; l[2]  = s2_q.m46 ^ s2_q.m48;
    l[3]  = s2_q.m47 ^ s2_q.m55; l[4]  = s2_q.m54 ^ s2_q.m58; l[5]  = s2_q.m49 ^ s2_q.m61;
    l[6]  = s2_q.m62 ^ l[5];     l[7]  = s2_q.m46 ^ l[3];     l[8]  = s2_q.m51 ^ s2_q.m59;
    l[9]  = s2_q.m52 ^ s2_q.m53; l[10] = s2_q.m53 ^ l[4];     l[11] = s2_q.m60 ^ l[2];
    l[12] = s2_q.m48 ^ s2_q.m51; l[13] = s2_q.m50 ^ l[0];     l[14] = s2_q.m52 ^ s2_q.m61;
    l[15] = s2_q.m55 ^ l[1];     l[16] = s2_q.m56 ^ l[0];     l[17] = s2_q.m57 ^ l[1];
    l[18] = s2_q.m58 ^ l[8];     l[19] = s2_q.m63 ^ l[4];     l[20] = l[0] ^ l[1];
    l[21] = l[1] ^ l[7];         l[22] = l[3] ^ l[12];        l[23] = l[18] ^ l[2];
    l[24] = l[15] ^ l[9];        l[25] = l[6] ^ l[10];        l[26] = l[7] ^ l[9];
    l[27] = l[8] ^ l[10];        l[28] = l[11] ^ l[14];       l[29] = l[11] ^ l[17];
    s3_d = {l[6] ^ l[24], ~(l[16] ^ l[26]), ~(l[19] ^ l[28]), l[6] ^ l[21],
            l[20] ^ l[22], l[25] ^ l[29], ~(l[13] ^ l[27]), ~(l[6] ^ l[23])};
  end
  // Valid bits: each stage refills when it is empty or its successor moves on; flush empties all
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else if (flush) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid && in_ready;
      if (adv2) v2_q <= v1_q;
      if (adv3) v3_q <= v2_q;
    end
  end
  // Data registers follow the same advance enables so a stalled output stays put
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      if (adv1) s1_q <= s1_d;
      if (adv2) s2_q <= s2_d;
      if (adv3) s3_q <= s3_d;
    end
  end
endmodule

// File: doc/sbox_forward_pipe.md
SBOX_FORWARD_PIPE -- requirements
Module: sbox_forward_pipe

Interface
REQ-001 Parameters: none; pipeline depth fixed at 3 register stages.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous clear of all in-flight entries.
REQ-005 in_valid  input  1  in_data holds a byte to substitute.
REQ-006 in_ready  output  1  block accepts in_data this cycle.
REQ-007 in_data  input  8  input byte, bit 7 = MSB.
REQ-008 out_valid  output  1  out_data holds a substituted byte.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  8  forward AES S-box of the accepted byte.
REQ-011 busy  output  1  high while any stage holds a valid entry.

Function
REQ-012 out_data SHALL equal the FIPS-197 forward SubBytes value of the corresponding accepted in_data.
REQ-013 Datapath SHALL be the depth-16 forward circuit: forward top linear transform, GF(2^4)-tower nonlinear core, forward bottom linear transform with the 0x63 affine constant folded in.
REQ-014 Stage 1 SHALL register the top linear transform outputs; stage 2 SHALL register the nonlinear-core outputs; stage 3 SHALL register out_data.
REQ-015 Each stage SHALL hold a valid bit v1, v2, v3; out_valid = v3; busy = v1|v2|v3.
REQ-016 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-017 Stage k SHALL advance when it is empty or stage k+1 advances; stage 3 advances when !v3 or out_ready.
REQ-018 in_ready SHALL equal !v1 or stage-1 advance; it SHALL NOT depend combinationally on in_valid.
REQ-019 Latency with no backpressure SHALL be exactly 3 cycles from input transfer to out_valid.
REQ-020 Throughput SHALL be one byte per cycle when out_ready stays high.
REQ-021 While out_valid && !out_ready, out_data SHALL remain stable and no entry SHALL be lost or duplicated.
REQ-022 Bubbles SHALL collapse: an empty stage SHALL accept from its predecessor even when later stages are stalled.
REQ-023 Full pipeline (v1,v2,v3 set) with out_ready low SHALL drive in_ready low.
REQ-024 Simultaneous output and input transfer when full SHALL be permitted (in_ready high if out_ready high).
REQ-025 flush SHALL clear v1..v3 on the next edge, override any same-cycle input transfer, and drive in_ready low during the flush cycle.
REQ-026 Data registers of empty stages are don't-care; out_data SHALL be 0x00 while !out_valid.
REQ-027 Bytes SHALL exit in acceptance order.

Reset
REQ-028 reset_n low SHALL immediately clear v1..v3 and all data registers to 0: out_valid=0, busy=0, out_data=0x00.
REQ-029 in_ready SHALL be 0 while reset_n is low and 1 on the first cycle after release.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight bytes; no output SHALL appear for them after release.

Verification
REQ-031 Single bytes 0x00, 0x01, 0x53, 0x10, 0xFF, out_ready=1 -> out_data 0x63, 0x7C, 0xED, 0xCA, 0x16, each exactly 3 cycles after acceptance.
REQ-032 Stream 0x00..0xFF back-to-back, out_ready=1 -> 256 outputs on consecutive cycles matching FIPS-197 table, in order.
REQ-033 Accept 0x53, 0x01, 0x00 with out_ready=0 -> in_ready drops after 3 accepts; out_data holds 0xED stable; raising out_ready yields 0xED, 0x7C, 0x63.
REQ-034 Random in_valid/out_ready toggling, 10k bytes -> scoreboard match, no loss or duplication, out_data stable under stall.
REQ-035 Fill pipeline, assert flush one cycle with in_valid=1 -> busy=0, out_valid=0 next cycle; flushed-cycle byte never appears.
REQ-036 Drop reset_n while 2 bytes in flight -> out_valid=0 immediately; after release, in_ready=1 and no stale output.
